// File: rtl/pit_seq.sv
// Programmable interval timer: prescaler and divider up-counters, chained by the
// prescaler terminal count, with a registered terminal pulse and sticky pending flag.
module pit_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resl,
  input  logic [WIDTH-1:0] din,
  input  logic             pre_wr,
  input  logic             div_wr,
  input  logic             en,
  input  logic             ack,
  output logic [WIDTH-1:0] pre_q,
  output logic [WIDTH-1:0] div_q,
  output logic             irq,
  output logic             pend,
  output logic             active
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] p_reg, p_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [WIDTH-1:0] pre_reg, pre_next;
  logic [WIDTH-1:0] div_reg, div_next;
  logic             irq_reg, irq_next;
  logic             pend_reg, pend_next;

  // Per-bit slices: ripple-carry incrementers and equality against the reload values.
  logic [WIDTH-1:0] pre_carry, div_carry;
  logic [WIDTH-1:0] pre_inc, div_inc;
  logic [WIDTH-1:0] pre_eq_bits, div_eq_bits;
  logic             pre_tc, div_tc;
  logic             wr;

  assign pre_carry[0] = 1'b1;
  assign div_carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
      assign pre_inc[gi]     = pre_reg[gi] ^ pre_carry[gi];
      assign div_inc[gi]     = div_reg[gi] ^ div_carry[gi];
      assign pre_eq_bits[gi] = ~(pre_reg[gi] ^ p_reg[gi]);
      assign div_eq_bits[gi] = ~(div_reg[gi] ^ d_reg[gi]);
      if (gi < WIDTH - 1) begin : g_carry
        assign pre_carry[gi+1] = pre_reg[gi] & pre_carry[gi];
        assign div_carry[gi+1] = div_reg[gi] & div_carry[gi];
      end
    end
  endgenerate

  assign pre_tc = &pre_eq_bits;
  assign div_tc = &div_eq_bits;
  assign wr     = pre_wr | div_wr;

  always_comb begin
    state_next = state_reg;
    p_next     = pre_wr ? din : p_reg;
    d_next     = div_wr ? din : d_reg;
    pre_next   = '0;
    div_next   = '0;
    irq_next   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (en) state_next = LOAD;
      end
      LOAD: begin
        if (!en)     state_next = IDLE;
        else if (wr) state_next = LOAD;
        else         state_next = RUN;
      end
      RUN: begin
        // Disable or a reload write both abort the period with no pulse.
        if (!en) begin
          state_next = IDLE;
        end else if (wr) begin
          state_next = LOAD;
        end else begin
          state_next = RUN;
          pre_next   = pre_tc ? '0 : pre_inc;
          if (pre_tc) div_next = div_tc ? '0 : div_inc;
          else        div_next = div_reg;
          irq_next   = pre_tc & div_tc;
        end
      end
      default: state_next = IDLE;
    endcase

    // A new pulse wins over a simultaneous acknowledge.
    pend_next = irq_next | (pend_reg & ~ack);
  end

  always_ff @(posedge clk or negedge resl) begin
    if (!resl) begin
      state_reg <= IDLE;
      p_reg     <= '0;
      d_reg     <= '0;
      pre_reg   <= '0;
      div_reg   <= '0;
      irq_reg   <= 1'b0;
      pend_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      p_reg     <= p_next;
      d_reg     <= d_next;
      pre_reg   <= pre_next;
      div_reg   <= div_next;
      irq_reg   <= irq_next;
      pend_reg  <= pend_next;
    end
  end

  assign pre_q  = pre_reg;
  assign div_q  = div_reg;
  assign irq    = irq_reg;
  assign pend   = pend_reg;
  assign active = (state_reg != IDLE);

endmodule

// File: tb/tb_pit_seq.sv
// Directed bench for pit_seq: a per-cycle vector table for the P=2/D=1 period
// plus hand sequences for P=D=0, restart-by-write and mid-period reset.
module tb_pit_seq;

  logic        clk;
  logic        resl;
  logic [15:0] din;
  logic        pre_wr;
  logic        div_wr;
  logic        en;
  logic        ack;
  logic [15:0] pre_q;
  logic [15:0] div_q;
  logic        irq;
  logic        pend;
  logic        active;

  int n_checks = 0;
  int n_fail   = 0;

  pit_seq #(.WIDTH(16)) dut (
    .clk    (clk),
    .resl   (resl),
    .din    (din),
    .pre_wr (pre_wr),
    .div_wr (div_wr),
    .en     (en),
    .ack    (ack),
    .pre_q  (pre_q),
    .div_q  (div_q),
    .irq    (irq),
    .pend   (pend),
    .active (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pre_wr;
    logic        div_wr;
    logic        en;
    logic        ack;
    logic [15:0] din;
    logic [15:0] pre_q;
    logic [15:0] div_q;
    logic        irq;
    logic        pend;
    logic        active;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic pw, logic dw, logic e, logic a, logic [15:0] d,
                              logic [15:0] pq, logic [15:0] dq, logic i, logic p, logic act);
    vec_t v;
    v.pre_wr = pw; v.div_wr = dw; v.en = e; v.ack = a; v.din = d;
    v.pre_q = pq; v.div_q = dq; v.irq = i; v.pend = p; v.active = act;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pw, input logic dw, input logic e, input logic a,
                       input logic [15:0] d);
    pre_wr = pw; div_wr = dw; en = e; ack = a; din = d;
  endtask

  initial begin
    resl = 1'b0;
    drive(0, 0, 0, 0, 16'h0);
    #12;
    chk("reset_pre_q", 32'(pre_q), 0);
    chk("reset_div_q", 32'(div_q), 0);
    chk("reset_irq", 32'(irq), 0);
    chk("reset_pend", 32'(pend), 0);
    chk("reset_active", 32'(active), 0);
    resl = 1'b1;
    step();

    // P=2, D=1: irq after E0+7, E0+13, E0+19; ack coincides with the E0+13 pulse.
    //              pw dw en ak din  pq dq irq pend act
    vecs.push_back(mk(1, 0, 0, 0, 2,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 0, 0, 1)); // E0
    vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 0, 0, 1)); // E0+1
    vecs.push_back(mk(0, 0, 1, 0, 0,  1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0,  2, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0,  0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0,  1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0,  2, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 1, 1, 1)); // E0+7
    vecs.push_back(mk(0, 0, 1, 0, 0,  1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0,  2, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0,  0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0,  1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0,  2, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0,  0, 0, 1, 1, 1)); // E0+13, ack with set
    vecs.push_back(mk(0, 0, 1, 1, 0,  1, 0, 0, 0, 1)); // lone ack
    vecs.push_back(mk(0, 0, 1, 0, 0,  2, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0,  0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0,  1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0,  2, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 1, 1, 1)); // E0+19
    vecs.push_back(mk(0, 0, 1, 0, 0,  1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0,  2, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0,  0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0,  1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0,  2, 1, 0, 1, 1)); // pre=P, div=D
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 0)); // en dropped: no irq
    vecs.push_back(mk(0, 0, 0, 1, 0,  0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].pre_wr, vecs[i].div_wr, vecs[i].en, vecs[i].ack, vecs[i].din);
      step();
      $display("vec %0d: pre_q=%0d div_q=%0d irq=%0b pend=%0b active=%0b",
               i, pre_q, div_q, irq, pend, active);
      chk($sformatf("vec%0d_pre_q", i), 32'(pre_q), 32'(vecs[i].pre_q));
      chk($sformatf("vec%0d_div_q", i), 32'(div_q), 32'(vecs[i].div_q));
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].irq));
      chk($sformatf("vec%0d_pend", i), 32'(pend), 32'(vecs[i].pend));
      chk($sformatf("vec%0d_active", i), 32'(active), 32'(vecs[i].active));
    end

    // P=D=0 via a simultaneous write: irq continuous from E0+2, pend held despite ack.
    drive(1, 1, 0, 0, 16'h0);
    step();
    drive(0, 0, 1, 1, 16'h0);
    step();
    chk("zz_e0_active", 32'(active), 1);
    chk("zz_e0_irq", 32'(irq), 0);
    step();
    chk("zz_e1_irq", 32'(irq), 0);
    for (int k = 2; k < 7; k++) begin
      step();
      $display("zz E0+%0d: irq=%0b pend=%0b", k, irq, pend);
      chk($sformatf("zz_e%0d_irq", k), 32'(irq), 1);
      chk($sformatf("zz_e%0d_pend", k), 32'(pend), 1);
      chk($sformatf("zz_e%0d_pre_q", k), 32'(pre_q), 0);
    end
    drive(0, 0, 0, 0, 16'h0);
    step();
    chk("zz_off_irq", 32'(irq), 0);
    chk("zz_off_active", 32'(active), 0);
    chk("zz_off_pend", 32'(pend), 1);
    drive(0, 0, 0, 1, 16'h0);
    step();
    chk("zz_ack_pend", 32'(pend), 0);

    // P=3, D=0 running; div_wr=2 at pre_q=2 restarts: next irq at W+13 only.
    drive(1, 0, 0, 0, 16'd3);
    step();
    drive(0, 1, 0, 0, 16'd0);
    step();
    drive(0, 0, 1, 0, 16'd0);
    step();   // E0
    step();   // E0+1
    step();
    step();
    chk("rs_pre_before_wr", 32'(pre_q), 2);
    drive(0, 1, 1, 0, 16'd2);
    step();   // W
    $display("rs W: active=%0b irq=%0b", active, irq);
    chk("rs_w_active", 32'(active), 1);
    chk("rs_w_irq", 32'(irq), 0);
    drive(0, 0, 1, 0, 16'd0);
    for (int k = 1; k <= 13; k++) begin
      step();
      $display("rs W+%0d: pre_q=%0d div_q=%0d irq=%0b", k, pre_q, div_q, irq);
      chk($sformatf("rs_w%0d_irq", k), 32'(irq), (k == 13) ? 1 : 0);
      if (k == 1) chk("rs_w1_pre_q", 32'(pre_q), 0);
      if (k == 2) chk("rs_w2_pre_q", 32'(pre_q), 1);
      if (k == 9) chk("rs_w9_div_q", 32'(div_q), 2);
    end
    chk("rs_w13_pend", 32'(pend), 1);

    // Asynchronous reset mid-period, then re-enable with cleared reloads.
    #2;
    resl = 1'b0;
    #1;
    $display("rst: pre_q=%0d div_q=%0d irq=%0b pend=%0b active=%0b",
             pre_q, div_q, irq, pend, active);
    chk("arst_pre_q", 32'(pre_q), 0);
    chk("arst_div_q", 32'(div_q), 0);
    chk("arst_irq", 32'(irq), 0);
    chk("arst_pend", 32'(pend), 0);
    chk("arst_active", 32'(active), 0);
    drive(0, 0, 0, 0, 16'd0);
    #1;
    resl = 1'b1;
    step();
    chk("arst_idle_active", 32'(active), 0);
    drive(0, 0, 1, 0, 16'd0);
    step();   // E0
    chk("arst_e0_active", 32'(active), 1);
    step();
    chk("arst_e1_irq", 32'(irq), 0);
    step();
    $display("arst E0+2: irq=%0b", irq);
    chk("arst_e2_irq", 32'(irq), 1);
    chk("arst_e2_pre_q", 32'(pre_q), 0);
    step();
    chk("arst_e3_irq", 32'(irq), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
